// File: rtl/eth_cmd_rx.sv
// eth_cmd_rx: GMII rx command decoder.
// Turns filtered, checksummed frames into one-cycle command strobes.
module eth_cmd_rx #(
    parameter logic [47:0] LOCAL_MAC    = 48'h000A35010203,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETH_TYPE     = 16'h88B5,
    parameter logic [15:0] MAGIC        = 16'hA55A,
    parameter int          MAX_PRE      = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rxdv,
    input  logic [7:0]  i_rxd,
    input  logic        i_cmd_finish,
    output logic        o_cmd_come,
    output logic [15:0] o_cmd,
    output logic [31:0] o_param,
    output logic [47:0] o_src_mac,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_PAY,
        S_TAIL,
        S_ISSUE,
        S_DROP
    } state_t;

    localparam logic [4:0] PRE_MAX = 5'(MAX_PRE);

    state_t        state_q, state_d;
    logic [4:0]    pre_cnt_q, pre_cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [103:0]  hdr_q, hdr_d;
    logic [47:0]   pay_q, pay_d;
    logic [7:0]    xor_q, xor_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [31:0]   param_q, param_d;
    logic [47:0]   src_q, src_d;
    logic          busy_q, busy_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    drop_q, drop_d;

    logic [111:0]  hdr_full;
    logic [47:0]   dst_w;
    logic [15:0]   type_w;
    logic [15:0]   magic_w;
    logic          dst_ok;
    logic          busy_eff;
    logic          fire;
    logic          err_inc;
    logic          drop_inc;

    // Header bytes are checked on the fly with the byte being received.
    assign hdr_full = {hdr_q, i_rxd};
    assign dst_w    = hdr_full[111:64];
    assign type_w   = hdr_full[15:0];
    assign magic_w  = {pay_q[7:0], i_rxd};
    assign dst_ok   = (dst_w == LOCAL_MAC) ||
                      (ACCEPT_BCAST && (dst_w == 48'hFFFF_FFFF_FFFF));

    assign busy_eff = busy_q & ~i_cmd_finish;
    assign fire     = (state_q == S_ISSUE) & ~busy_eff;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        pay_d     = pay_q;
        xor_d     = xor_q;
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        unique case (state_q)
            // ISSUE also accepts the next frame's first byte (one-cycle gap).
            S_IDLE, S_ISSUE: begin
                if ((state_q == S_ISSUE) && busy_eff) begin
                    drop_inc = 1'b1;
                end
                state_d = S_IDLE;
                if (i_rxdv) begin
                    if (i_rxd == 8'h55) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 5'd1;
                    end else begin
                        state_d = S_DROP;
                        err_inc = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (!i_rxdv) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else if (i_rxd == 8'h55) begin
                    if (pre_cnt_q >= PRE_MAX) begin
                        state_d = S_DROP;
                        err_inc = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 5'd1;
                    end
                end else if (i_rxd == 8'hD5) begin
                    state_d = S_HDR;
                    idx_d   = 4'd0;
                end else begin
                    state_d = S_DROP;
                    err_inc = 1'b1;
                end
            end
            S_HDR: begin
                if (!i_rxdv) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else begin
                    hdr_d = hdr_full[103:0];
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd13) begin
                        // Foreign traffic is not an error.
                        if (!dst_ok || (type_w != ETH_TYPE)) begin
                            state_d = S_DROP;
                        end else begin
                            state_d = S_PAY;
                            idx_d   = 4'd0;
                            xor_d   = 8'h00;
                        end
                    end
                end
            end
            S_PAY: begin
                if (!i_rxdv) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q < 4'd8) begin
                        pay_d = {pay_q[39:0], i_rxd};
                    end
                    if ((idx_q >= 4'd2) && (idx_q <= 4'd7)) begin
                        xor_d = xor_q ^ i_rxd;
                    end
                    if ((idx_q == 4'd1) && (magic_w != MAGIC)) begin
                        state_d = S_DROP;
                        err_inc = 1'b1;
                    end
                    if (idx_q == 4'd8) begin
                        if (i_rxd != xor_q) begin
                            state_d = S_DROP;
                            err_inc = 1'b1;
                        end else begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (!i_rxdv) begin
                    state_d = S_ISSUE;
                end
            end
            S_DROP: begin
                if (!i_rxdv) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Issued values appear in the strobe cycle itself, then hold.
    always_comb begin
        cmd_d   = cmd_q;
        param_d = param_q;
        src_d   = src_q;
        if (fire) begin
            cmd_d   = pay_q[47:32];
            param_d = pay_q[31:0];
            src_d   = hdr_q[63:16];
        end
        busy_d = fire | busy_eff;
        err_d  = err_q;
        drop_d = drop_q;
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= 5'd0;
            idx_q     <= 4'd0;
            hdr_q     <= '0;
            pay_q     <= '0;
            xor_q     <= 8'h00;
            cmd_q     <= 16'h0000;
            param_q   <= 32'h0;
            src_q     <= 48'h0;
            busy_q    <= 1'b0;
            err_q     <= 8'h00;
            drop_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            pay_q     <= pay_d;
            xor_q     <= xor_d;
            cmd_q     <= cmd_d;
            param_q   <= param_d;
            src_q     <= src_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign o_cmd_come = fire;
    assign o_cmd      = cmd_d;
    assign o_param    = param_d;
    assign o_src_mac  = src_d;
    assign o_busy     = busy_q;
    assign o_err_cnt  = err_q;
    assign o_drop_cnt = drop_q;

endmodule
